// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared constants and helpers for the LED PWM output stage.
//               Provides the channel count, the default PWM counter width and
//               the square-law duty helper used by the gamma build.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int LED_N            = 8;
    localparam int PWM_BITS_DEFAULT = 8;

    // Square-law perceptual duty: (level * level) >> bits.
    // Levels wider than 16 bits are not supported by this helper.
    function automatic logic [31:0] gamma_sq(input logic [15:0] level, input int bits);
        logic [31:0] sq;
        sq = {16'h0000, level} * {16'h0000, level};
        return sq >> bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_fade_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_fade_channel
// Description : One LED channel. Holds the brightness level, applies the
//               saturating fade update on each step event and produces the
//               registered PWM bit by comparing the frame counter to the duty.
//               Optional macro LED_PWM_FADER_GAMMA_EN selects a square-law
//               duty curve; otherwise duty equals the level.
// Revision    : 1.0 - initial release
// ============================================================================
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEFAULT,
    parameter int FADE_STEP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                target,
    input  logic                step,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_pwm
);

    // One extra bit of headroom so level + FADE_STEP never wraps.
    localparam logic [PWM_BITS:0]   STEP_AMT  = (PWM_BITS+1)'(FADE_STEP);
    localparam logic [PWM_BITS-1:0] STEP_LO   = STEP_AMT[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_next;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS:0]   sum;
    logic                pwm_next;

`ifdef LED_PWM_FADER_GAMMA_EN
    assign duty = PWM_BITS'(gamma_sq(16'(level), PWM_BITS));
`else
    assign duty = level;
`endif

    // Saturating fade: ramp up toward the brightness cap, or down toward zero.
    always_comb begin
        sum        = {1'b0, level} + STEP_AMT;
        level_next = level;
        if (target) begin
            // Also pulls the level down when the cap drops below it.
            if (sum > {1'b0, brightness}) begin
                level_next = brightness;
            end else begin
                level_next = sum[PWM_BITS-1:0];
            end
        end else begin
            if ({1'b0, level} > STEP_AMT) begin
                level_next = level - STEP_LO;
            end else begin
                level_next = '0;
            end
        end
    end

    // PWM decision: zero is dark, full scale is solid on, else counter vs duty.
    always_comb begin
        pwm_next = 1'b0;
        if (level == LEVEL_MAX) begin
            pwm_next = 1'b1;
        end else if (level != '0) begin
            pwm_next = (pwm_cnt < duty);
        end
    end

    // Level and output registers; disable clears everything on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= '0;
            led_pwm <= 1'b0;
        end else if (!enable) begin
            level   <= '0;
            led_pwm <= 1'b0;
        end else begin
            if (step) begin
                level <= level_next;
            end
            led_pwm <= pwm_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_fader
// Description : LED output stage. Turns the on/off pattern from the mode
//               drivers into faded PWM drive. Owns the frame counter, the
//               fade-step divider, the frame-boundary target register and the
//               frame_start marker; per-LED work lives in led_fade_channel.
//               Optional macro LED_PWM_FADER_GAMMA_EN selects square-law duty.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEFAULT,
    parameter int FADE_STEP = 8,
    parameter int STEP_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [LED_N-1:0]    led_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [LED_N-1:0]    led_pwm,
    output logic                frame_start
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam int                  SC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SC_W-1:0]     SC_LAST = SC_W'(STEP_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SC_W-1:0]     step_cnt;
    logic [LED_N-1:0]    target;
    logic                frame_end;
    logic                step_evt;

    assign frame_end = enable && (pwm_cnt == CNT_MAX);
    assign step_evt  = frame_end && (step_cnt == SC_LAST);

    // Free-running frame counter, parked at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (!enable) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Counts frame ends; the wrap is the fade step event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (!enable) begin
            step_cnt <= '0;
        end else if (frame_end) begin
            step_cnt <= step_evt ? '0 : step_cnt + SC_W'(1);
        end
    end

    // Target is only sampled at the frame boundary so mid-frame glitches vanish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
        end else if (!enable) begin
            target <= '0;
        end else if (frame_end) begin
            target <= led_in;
        end
    end

    // Registered alongside led_pwm, so it marks the output cycle driven by pwm_cnt==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= enable && (pwm_cnt == '0);
        end
    end

    for (genvar i = 0; i < LED_N; i++) begin : g_channel
        led_fade_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .enable     (enable),
            .target     (target[i]),
            .step       (step_evt),
            .brightness (brightness),
            .pwm_cnt    (pwm_cnt),
            .led_pwm    (led_pwm[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_fader
// Description : Directed bench for led_pwm_fader with PWM_BITS=4, STEP_DIV=2.
//               Main instance uses FADE_STEP=1; a second instance uses
//               FADE_STEP=8 with brightness 12 for the clamping sequence.
//               Per-frame high counts are compared against a frame-level
//               model plus hand-derived values at key frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_fader;

    localparam int FS = 1;
    localparam int SD = 2;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       enable     = 1'b1;
    logic [7:0] led_in     = 8'h00;
    logic [3:0] brightness = 4'd15;
    logic [7:0] led_pwm;
    logic       frame_start;

    logic       en8  = 1'b0;
    logic [7:0] led8 = 8'hFF;
    logic [3:0] bri8 = 4'd12;
    logic [7:0] pwm8;
    logic       fs8;

    int n_vec = 0;
    int n_bad = 0;

    int         m_lvl [8];
    logic [7:0] m_tgt;
    int         m_sc;
    bit         m_first;

    logic [39:0] pk;
    int          stray;
    logic [7:0]  e8;

    always #5 clk = ~clk;

    led_pwm_fader #(.PWM_BITS(4), .FADE_STEP(1), .STEP_DIV(2)) dut (
        .clk (clk), .rst_n (rst_n), .enable (enable), .led_in (led_in),
        .brightness (brightness), .led_pwm (led_pwm), .frame_start (frame_start)
    );

    led_pwm_fader #(.PWM_BITS(4), .FADE_STEP(8), .STEP_DIV(2)) dut8 (
        .clk (clk), .rst_n (rst_n), .enable (en8), .led_in (led8),
        .brightness (bri8), .led_pwm (pwm8), .frame_start (fs8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // High cycles per 16-cycle frame for a given level.
    function automatic int exp_cnt(input int l);
        if (l == 0) return 0;
        if (l == 15) return 16;
`ifdef LED_PWM_FADER_GAMMA_EN
        return (l * l) >> 4;
`else
        return l;
`endif
    endfunction

    function automatic logic [39:0] rep(input int c);
        logic [39:0] r;
        for (int i = 0; i < 8; i++) r[i*5 +: 5] = 5'(c);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
        m_tgt   = 8'h00;
        m_sc    = 0;
        m_first = 1'b1;
    endtask

    // Measure one output frame (sel=0 main DUT, sel=1 FADE_STEP=8 DUT).
    // New main-DUT inputs are applied mid-frame so the next boundary samples them.
    task automatic run_frame(input bit sel, input logic [7:0] nled, input logic [3:0] nbri,
                             output logic [39:0] cnt_pk);
        int         waited;
        int         strays;
        int         cnt [8];
        logic [7:0] p;
        logic [39:0] exp_pk;
        waited = 0;
        strays = 0;
        cnt_pk = '0;
        exp_pk = '0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(sel ? fs8 : frame_start) && waited <= 40);
        if (sel) check("fs8_wait", 64'(waited), 64'd1);
        else     check("fs_wait", 64'(waited), 64'd1);
        if (!sel) begin
            if (!m_first) begin
                if (m_sc == SD - 1) begin
                    for (int i = 0; i < 8; i++) begin
                        if (m_tgt[i])
                            m_lvl[i] = (m_lvl[i] + FS > int'(brightness)) ? int'(brightness) : m_lvl[i] + FS;
                        else
                            m_lvl[i] = (m_lvl[i] > FS) ? m_lvl[i] - FS : 0;
                    end
                    m_sc = 0;
                end else begin
                    m_sc++;
                end
                m_tgt = led_in;
            end
            m_first = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (sel ? fs8 : frame_start) strays++;
            end
            p = sel ? pwm8 : led_pwm;
            for (int i = 0; i < 8; i++) cnt[i] += int'(p[i]);
            if (k == 8 && !sel) begin
                led_in     = nled;
                brightness = nbri;
            end
        end
        check("fs_stray", 64'(strays), 64'd0);
        for (int i = 0; i < 8; i++) cnt_pk[i*5 +: 5] = 5'(cnt[i]);
        if (!sel) begin
            for (int i = 0; i < 8; i++) exp_pk[i*5 +: 5] = 5'(exp_cnt(m_lvl[i]));
            check("frame", 64'(cnt_pk), 64'(exp_pk));
        end
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_pwm", 64'(led_pwm), 64'd0);
        check("rst_fs", 64'(frame_start), 64'd0);
        check("rst_pwm8", 64'(pwm8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Dark pattern, then LED0 requested mid-frame and ramped to full.
        run_frame(1'b0, 8'h00, 4'd15, pk);
        run_frame(1'b0, 8'h00, 4'd15, pk);
        run_frame(1'b0, 8'h01, 4'd15, pk);
        repeat (34) run_frame(1'b0, 8'h01, 4'd15, pk);
        check("led0_full", 64'(pk), 64'h10);

        // Cap drops to 6 while lit.
        run_frame(1'b0, 8'h01, 4'd6, pk);
        run_frame(1'b0, 8'h01, 4'd6, pk);
        run_frame(1'b0, 8'h01, 4'd6, pk);
        check("led0_cap6", 64'(pk), 64'(exp_cnt(6)));

        // Fade all off, then all on for four steps, then back off.
        run_frame(1'b0, 8'h00, 4'd15, pk);
        repeat (12) run_frame(1'b0, 8'h00, 4'd15, pk);
        check("all_off", 64'(pk), 64'd0);
        run_frame(1'b0, 8'hFF, 4'd15, pk);
        repeat (8) run_frame(1'b0, 8'hFF, 4'd15, pk);
        run_frame(1'b0, 8'h00, 4'd15, pk);
        check("peak4", 64'(pk), 64'(rep(exp_cnt(4))));
        run_frame(1'b0, 8'h00, 4'd15, pk);
        run_frame(1'b0, 8'h00, 4'd15, pk);
        check("fall3", 64'(pk), 64'(rep(exp_cnt(3))));
        repeat (8) run_frame(1'b0, 8'h00, 4'd15, pk);
        check("floor0", 64'(pk), 64'd0);

        // Mid-fade disable.
        run_frame(1'b0, 8'hFF, 4'd15, pk);
        repeat (5) run_frame(1'b0, 8'hFF, 4'd15, pk);
        @(negedge clk);
        e8 = (exp_cnt(2) > 0) ? 8'hFF : 8'h00;
        check("pre_dis_fs", 64'(frame_start), 64'd1);
        check("pre_dis_pwm", 64'(led_pwm), 64'(e8));
        enable = 1'b0;
        @(negedge clk);
        check("dis_pwm", 64'(led_pwm), 64'd0);
        check("dis_fs", 64'(frame_start), 64'd0);
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_start || led_pwm != 8'h00) stray++;
        end
        check("dis_quiet", 64'(stray), 64'd0);
        enable = 1'b1;
        model_reset();
        repeat (5) run_frame(1'b0, 8'hFF, 4'd15, pk);

        // Asynchronous reset in the middle of a lit frame.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_pwm", 64'(led_pwm), 64'd0);
        check("rst_async_fs", 64'(frame_start), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) run_frame(1'b0, 8'hFF, 4'd15, pk);

        // FADE_STEP=8, brightness 12: 0, 8, 12 (clamped), then hold.
        @(negedge clk);
        en8 = 1'b1;
        for (int f = 0; f < 8; f++) begin
            run_frame(1'b1, 8'h00, 4'd0, pk);
            check("fade8", 64'(pk), 64'(rep(exp_cnt((f < 2) ? 0 : (f < 4) ? 8 : 12))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
